mem_wb_stage: RTL and testbench

Memory-access stage plus MEM/WB pipeline register, sitting directly downstream of the EX/MEM register. Takes the registered ALU result, store data, destination register and control bits. Performs word loads and stores over a req/ack data-memory handshake, stalling upstream while a transfer is outstanding. Registers the write-back result for the register file.

---
 rtl/mem_wb_stage.sv | 126 ++++++++++++
 tb/tb_mem_wb_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage with req/ack data-memory handshake and MEM/WB register.
// Aligned loads/stores park in WAIT until ack or timeout; everything else retires in one cycle.
module mem_wb_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    input  logic        regwrite,
    input  logic        memread,
    input  logic        memwrite,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_regwrite,
    output logic        err_misalign,
    output logic        err_timeout
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [4:0]    lat_rd;
    logic          lat_regwrite;
    logic          lat_load;
    logic          mem_op;
    logic          misaligned;
    logic          tmo;

    assign mem_op     = memread | memwrite;
    assign misaligned = |alu_result[1:0];
    // ack in the final WAIT cycle takes precedence over the abort
    assign tmo        = (state == WAIT) && !mem_ack && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        if (state == IDLE) begin
            if (in_valid && mem_op && !misaligned) begin
                stall    = 1'b1;
                state_nx = WAIT;
            end
        end else begin
            stall = !mem_ack && !tmo;
            if (mem_ack || tmo) state_nx = IDLE;
        end
        if (rst) stall = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            lat_rd       <= '0;
            lat_regwrite <= 1'b0;
            lat_load     <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_regwrite  <= 1'b0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            err_misalign <= 1'b0;
            if (state == IDLE) begin
                if (in_valid && !mem_op) begin
                    wb_valid    <= 1'b1;
                    wb_data     <= alu_result;
                    wb_rd       <= rd;
                    wb_regwrite <= regwrite;
                end else if (in_valid && misaligned) begin
                    wb_valid     <= 1'b1;
                    wb_data      <= alu_result;
                    wb_rd        <= rd;
                    wb_regwrite  <= 1'b0;
                    err_misalign <= 1'b1;
                end else if (in_valid) begin
                    mem_req      <= 1'b1;
                    mem_we       <= memwrite;
                    mem_addr     <= alu_result;
                    mem_wdata    <= store_data;
                    lat_rd       <= rd;
                    lat_regwrite <= regwrite;
                    lat_load     <= !memwrite;
                    cnt          <= '0;
                end
            end else if (mem_ack) begin
                mem_req     <= 1'b0;
                wb_valid    <= 1'b1;
                wb_rd       <= lat_rd;
                wb_data     <= lat_load ? mem_rdata : mem_addr;
                wb_regwrite <= lat_load & lat_regwrite;
            end else if (tmo) begin
                mem_req     <= 1'b0;
                wb_valid    <= 1'b1;
                wb_rd       <= lat_rd;
                wb_data     <= mem_addr;
                wb_regwrite <= 1'b0;
                err_timeout <= 1'b1;
            end else if (cnt != CW'(TIMEOUT - 1)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vectors with hand-computed expectations for mem_wb_stage.
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic [4:0]  rd = '0;
    logic        regwrite = 1'b0;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        err_misalign;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    mem_wb_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
        .store_data(store_data), .rd(rd), .regwrite(regwrite), .memread(memread),
        .memwrite(memwrite), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .err_misalign(err_misalign), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] r, input logic rw, input logic mr, input logic mw);
        in_valid = v; alu_result = a; store_data = sd; rd = r;
        regwrite = rw; memread = mr; memwrite = mw;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        tick;
        tick;
        chk("rst_stall", stall, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_wbd", wb_data, 0);
        chk("rst_tmo", err_timeout, 0);
        rst = 1'b0;

        drive(1, 32'h1234, 0, 5, 1, 0, 0);
        #1 chk("alu_stall", stall, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("alu_wbv", wb_valid, 1);
        chk("alu_wbd", wb_data, 32'h1234);
        chk("alu_rd", wb_rd, 5);
        chk("alu_rw", wb_regwrite, 1);
        tick;
        chk("idle_wbv", wb_valid, 0);
        chk("idle_hold", wb_data, 32'h1234);

        drive(1, 32'h100, 0, 3, 1, 1, 0);
        n = 0;
        #1 n += int'(stall);
        tick;
        chk("ld_req", mem_req, 1);
        chk("ld_addr", mem_addr, 32'h100);
        chk("ld_we", mem_we, 0);
        n += int'(stall);
        tick;
        n += int'(stall);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        #1 chk("ld_ack_stall", stall, 0);
        chk("ld_stall_cycles", n, 3);
        tick;
        mem_ack = 0;
        chk("ld_wbv", wb_valid, 1);
        chk("ld_wbd", wb_data, 32'hDEADBEEF);
        chk("ld_rd", wb_rd, 3);
        chk("ld_rw", wb_regwrite, 1);
        chk("ld_req_low", mem_req, 0);

        drive(1, 32'h200, 32'hCAFEF00D, 7, 1, 0, 1);
        #1 chk("st_stall", stall, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("st_we", mem_we, 1);
        chk("st_wdata", mem_wdata, 32'hCAFEF00D);
        mem_ack = 1;
        #1 chk("st_ack_stall", stall, 0);
        tick;
        mem_ack = 0;
        chk("st_wbv", wb_valid, 1);
        chk("st_rw", wb_regwrite, 0);
        chk("st_wbd", wb_data, 32'h200);

        drive(1, 32'h102, 0, 4, 1, 1, 0);
        #1 chk("mis_stall", stall, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("mis_req", mem_req, 0);
        chk("mis_err", err_misalign, 1);
        chk("mis_wbv", wb_valid, 1);
        chk("mis_rw", wb_regwrite, 0);
        tick;
        chk("mis_pulse", err_misalign, 0);
        chk("mis_req2", mem_req, 0);

        drive(1, 32'h300, 0, 6, 1, 1, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            n += int'(stall);
            tick;
        end
        chk("tmo_stall_cycles", n, 15);
        chk("tmo_last_stall", stall, 0);
        chk("tmo_req_still", mem_req, 1);
        tick;
        chk("tmo_req", mem_req, 0);
        chk("tmo_wbv", wb_valid, 1);
        chk("tmo_rw", wb_regwrite, 0);
        chk("tmo_err", err_timeout, 1);
        drive(1, 32'h55, 0, 2, 1, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("tmo_alu_wbd", wb_data, 32'h55);
        chk("tmo_sticky", err_timeout, 1);

        rst = 1;
        tick;
        rst = 0;
        chk("rst2_tmo", err_timeout, 0);
        drive(1, 32'h400, 0, 8, 1, 1, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) tick;
        mem_ack = 1; mem_rdata = 32'h12345678;
        #1 chk("race_stall", stall, 0);
        tick;
        mem_ack = 0;
        chk("race_wbv", wb_valid, 1);
        chk("race_wbd", wb_data, 32'h12345678);
        chk("race_rw", wb_regwrite, 1);
        chk("race_tmo", err_timeout, 0);

        drive(1, 32'h500, 0, 10, 1, 1, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("mid_req", mem_req, 1);
        #1 rst = 1;
        #1;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wbd", wb_data, 0);
        chk("mid_rst_stall", stall, 0);
        tick;
        rst = 0;
        drive(1, 32'h77, 0, 9, 1, 0, 0);
        mem_ack = 1; mem_rdata = 32'hBADBAD00;
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("late_wbd", wb_data, 32'h77);
        chk("late_rd", wb_rd, 9);
        chk("late_req", mem_req, 0);
        tick;
        mem_ack = 0;
        chk("late_wbv", wb_valid, 0);
        chk("late_req2", mem_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
